// File: rtl/ps2_mouse_rx.sv
// ps2_mouse_rx: PS/2 mouse packet receiver; define PS2_MOUSE_OVF_CLAMP_EN to clamp overflowed axes
module ps2_mouse_rx #(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT_TICKS = 2000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       New_Clk,
  input  logic       PS2_Clk,
  input  logic       PS2_Data,
  output logic [2:0] Buttons,
  output logic [8:0] Dx,
  output logic [8:0] Dy,
  output logic       Pkt_Valid,
  output logic       Frame_Err
);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state;
  logic [2:0] nc_s;
  logic [1:0] pc_s, pd_s;
  logic [FILTER_LEN-1:0] hist, nxt;
  logic filt, tick, fall, d, ok, active;
  logic [2:0] cnt, btn;
  logic [7:0] sh, b1;
  logic par, sx, sy;
  logic [1:0] idx;
  logic [TW-1:0] tmo;
  logic [8:0] dx_n, dy_n;
`ifdef PS2_MOUSE_OVF_CLAMP_EN
  logic [1:0] ovf;
  assign dx_n = ovf[0] ? (sx ? 9'h100 : 9'h0FF) : {sx, b1};
  assign dy_n = ovf[1] ? (sy ? 9'h100 : 9'h0FF) : {sy, sh};
`else
  assign dx_n = {sx, b1};
  assign dy_n = {sy, sh};
`endif
  assign tick = nc_s[1] & ~nc_s[2];
  assign nxt = {hist[FILTER_LEN-2:0], pc_s[1]};
  assign fall = tick & filt & ~|nxt;
  assign d = pd_s[1];
  assign ok = d & ^{sh, par};
  assign active = (state != IDLE) || (idx != 2'd0);
  // Two-flop synchronizers; nc_s[2] keeps the previous New_Clk level for edge detection
  always_ff @(posedge Clk) begin
    if (Reset) begin
      nc_s <= '1;
      pc_s <= '1;
      pd_s <= '1;
    end else begin
      nc_s <= {nc_s[1:0], New_Clk};
      pc_s <= {pc_s[0], PS2_Clk};
      pd_s <= {pd_s[0], PS2_Data};
    end
  end
  // Glitch filter: the filtered clock moves only after FILTER_LEN equal samples
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hist <= '1;
      filt <= 1'b1;
    end else if (tick) begin
      hist <= nxt;
      filt <= (&nxt) ? 1'b1 : (~|nxt) ? 1'b0 : filt;
    end
  end
  // Frame FSM, packet assembly and inactivity timeout
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      par <= 1'b0;
      idx <= '0;
      tmo <= '0;
      btn <= '0;
      sx <= 1'b0;
      sy <= 1'b0;
      b1 <= '0;
`ifdef PS2_MOUSE_OVF_CLAMP_EN
      ovf <= '0;
`endif
      Buttons <= '0;
      Dx <= '0;
      Dy <= '0;
      Pkt_Valid <= 1'b0;
      Frame_Err <= 1'b0;
    end else begin
      Pkt_Valid <= 1'b0;
      Frame_Err <= 1'b0;
      if (fall) begin
        tmo <= '0;
        case (state)
          IDLE: begin
            cnt <= '0;
            if (!d) state <= DATA;
          end
          DATA: begin
            sh <= {d, sh[7:1]};
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par <= d;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!ok) begin
              Frame_Err <= 1'b1;
              idx <= '0;
            end else if (idx == 2'd0) begin
              if (sh[3]) begin
                btn <= sh[2:0];
                sx <= sh[4];
                sy <= sh[5];
`ifdef PS2_MOUSE_OVF_CLAMP_EN
                ovf <= sh[7:6];
`endif
                idx <= 2'd1;
              end
            end else if (idx == 2'd1) begin
              b1 <= sh;
              idx <= 2'd2;
            end else begin
              Buttons <= btn;
              Dx <= dx_n;
              Dy <= dy_n;
              Pkt_Valid <= 1'b1;
              idx <= '0;
            end
          end
        endcase
      end else if (tick && active) begin
        if (tmo == TW'(TIMEOUT_TICKS - 1)) begin
          Frame_Err <= 1'b1;
          idx <= '0;
          state <= IDLE;
          tmo <= '0;
        end else begin
          tmo <= tmo + 1'b1;
        end
      end else if (!active) begin
        tmo <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ps2_mouse_rx.sv
// tb_ps2_mouse_rx: directed self-checking bench for ps2_mouse_rx
module tb_ps2_mouse_rx;
  logic clk = 0, rst = 1, new_clk = 0, ps2_clk = 1, ps2_data = 1;
  logic [2:0] buttons;
  logic [8:0] dx, dy;
  logic pkt_valid, frame_err;
  int checks = 0, failures = 0, pv_cnt = 0, fe_cnt = 0, pv0 = 0, fe0 = 0;

  ps2_mouse_rx dut (
    .Clk(clk), .Reset(rst), .New_Clk(new_clk), .PS2_Clk(ps2_clk), .PS2_Data(ps2_data),
    .Buttons(buttons), .Dx(dx), .Dy(dy), .Pkt_Valid(pkt_valid), .Frame_Err(frame_err)
  );

  always #5 clk = ~clk;
  always begin
    repeat (4) @(posedge clk);
    #1 new_clk = ~new_clk;
  end
  always @(negedge clk) begin
    pv_cnt += int'(pkt_valid);
    fe_cnt += int'(frame_err);
    assert (!(pkt_valid && frame_err)) else begin
      failures++;
      $error("FAIL both_pulses observed=11 expected=not both");
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b, input int hp);
    ps2_data = b;
    cyc(hp * 8);
    ps2_clk = 0;
    cyc(hp * 8);
    ps2_clk = 1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad, input int hp);
    ps2_bit(1'b0, hp);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], hp);
    ps2_bit(~^b ^ bad, hp);
    ps2_bit(1'b1, hp);
    ps2_data = 1;
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int hp);
    send_byte(a, 0, hp);
    send_byte(b, 0, hp);
    send_byte(c, 0, hp);
    cyc(20);
  endtask

  task automatic mark();
    pv0 = pv_cnt;
    fe0 = fe_cnt;
  endtask

  task automatic check_pkt(input string tag, input logic [2:0] eb, input logic [8:0] ex, input logic [8:0] ey,
                           input int dpv, input int dfe);
    check({tag, "_buttons"}, 32'(buttons), 32'(eb));
    check({tag, "_dx"}, 32'(dx), 32'(ex));
    check({tag, "_dy"}, 32'(dy), 32'(ey));
    check({tag, "_pv_count"}, 32'(pv_cnt - pv0), 32'(dpv));
    check({tag, "_fe_count"}, 32'(fe_cnt - fe0), 32'(dfe));
  endtask

  initial begin
    cyc(5);
    check("rst_buttons", 32'(buttons), 0);
    check("rst_dx", 32'(dx), 0);
    check("rst_dy", 32'(dy), 0);
    check("rst_pv", 32'(pkt_valid), 0);
    check("rst_fe", 32'(frame_err), 0);
    rst = 0;
    cyc(50);
    mark();
    send_pkt(8'h09, 8'h05, 8'hFB, 16);
    check_pkt("basic", 3'b001, 9'h005, 9'h0FB, 1, 0);
    mark();
    send_pkt(8'h38, 8'h10, 8'hF0, 8);
    check_pkt("negative", 3'b000, 9'h110, 9'h1F0, 1, 0);
    mark();
    send_byte(8'h09, 1, 8);
    cyc(20);
    check("parity_fe", 32'(fe_cnt - fe0), 1);
    check("parity_pv", 32'(pv_cnt - pv0), 0);
    mark();
    send_pkt(8'h0A, 8'h01, 8'h02, 8);
    check_pkt("after_parity", 3'b010, 9'h001, 9'h002, 1, 0);
    mark();
    send_byte(8'h01, 0, 8);
    send_pkt(8'h0C, 8'h03, 8'h04, 8);
    check_pkt("resync", 3'b100, 9'h003, 9'h004, 1, 0);
    mark();
    send_byte(8'h09, 0, 8);
    send_byte(8'h07, 0, 8);
    cyc(2100 * 8);
    check("timeout_fe", 32'(fe_cnt - fe0), 1);
    check("timeout_pv", 32'(pv_cnt - pv0), 0);
    mark();
    send_pkt(8'h0B, 8'h11, 8'h22, 8);
    check_pkt("after_timeout", 3'b011, 9'h011, 9'h022, 1, 0);
    mark();
    send_pkt(8'h49, 8'hFF, 8'h00, 8);
    check_pkt("ovf_pos", 3'b001, 9'h0FF, 9'h000, 1, 0);
    mark();
    send_pkt(8'h59, 8'h00, 8'h00, 8);
    check_pkt("ovf_neg", 3'b001, 9'h100, 9'h000, 1, 0);
    mark();
    ps2_data = 0;
    cyc(1);
    ps2_clk = 0;
    cyc(1);
    ps2_clk = 1;
    ps2_data = 1;
    cyc(100);
    send_pkt(8'h0F, 8'h7F, 8'h80, 8);
    check_pkt("glitch", 3'b111, 9'h07F, 9'h080, 1, 0);
    mark();
    send_byte(8'h09, 0, 8);
    ps2_bit(1'b0, 8);
    ps2_bit(1'b1, 8);
    rst = 1;
    cyc(3);
    rst = 0;
    cyc(20);
    check_pkt("mid_reset", 3'b000, 9'h000, 9'h000, 0, 0);
    mark();
    send_pkt(8'h09, 8'h05, 8'hFB, 8);
    check_pkt("after_reset", 3'b001, 9'h005, 9'h0FB, 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
